fast_stopbit_field_decoder: RTL

//  Parametrised FAST stop-bit field decoder. Takes a C_LANES-byte AXIS beat stream, splits it into

---
 rtl/fast_stopbit_field_decoder_pkg.sv | 17 +
 rtl/fast_stopbit_field_decoder_stopbit_priority_enc.sv | 31 +++
 rtl/fast_stopbit_field_decoder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fast_stopbit_field_decoder_pkg.sv
// Shared constants and byte helpers for the FAST stop-bit field decoder.
package fast_stopbit_field_decoder_pkg;

  localparam int STOP_BIT     = 7;
  localparam int PAYLOAD_BITS = 7;

  // A byte terminates its field when its top bit is set.
  function automatic logic is_stop(input logic [7:0] b);
    return b[STOP_BIT];
  endfunction

  // The low seven bits carry the payload.
  function automatic logic [PAYLOAD_BITS-1:0] payload_of(input logic [7:0] b);
    return b[PAYLOAD_BITS-1:0];
  endfunction

endpackage

// File: rtl/fast_stopbit_field_decoder_stopbit_priority_enc.sv
// Finds the first kept stop byte at or after ptr, and whether any kept
// lane follows it (i.e. whether the beat still has work after this field).
module stopbit_priority_enc #(
  parameter int C_LANES = 4,
  parameter int PTR_W   = (C_LANES > 1) ? $clog2(C_LANES) : 1
) (
  input  logic [C_LANES-1:0] keep,
  input  logic [C_LANES-1:0] stop,
  input  logic [PTR_W-1:0]   ptr,
  output logic               found,
  output logic [PTR_W-1:0]   s,
  output logic               remaining_after_s
);

  // Scan downward so the lowest qualifying lane is the one left in s.
  always_comb begin
    found             = 1'b0;
    s                 = '0;
    remaining_after_s = 1'b0;
    for (int i = C_LANES - 1; i >= 0; i--) begin
      if (i >= int'(ptr) && keep[i] && stop[i]) begin
        found = 1'b1;
        s     = PTR_W'(i);
      end
    end
    for (int i = 0; i < C_LANES; i++) begin
      if (found && i > int'(s) && keep[i]) remaining_after_s = 1'b1;
    end
  end

endmodule

// File: rtl/fast_stopbit_field_decoder.sv
// FAST stop-bit field decoder: splits an AXIS byte stream into stop-bit
// terminated fields, concatenates 7-bit payloads big-endian across beats and
// emits one decoded field per cycle.
module fast_stopbit_field_decoder
  import fast_stopbit_field_decoder_pkg::*;
#(
  parameter int C_LANES           = 4,
  parameter int C_MAX_FIELD_BYTES = 8,
  parameter int C_STAT_WIDTH      = 32
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [C_LANES*8-1:0]                   in_tdata,
  input  logic [C_LANES-1:0]                     in_tkeep,
  input  logic                                   in_tvalid,
  input  logic                                   in_tlast,
  output logic                                   in_tready,
  output logic [PAYLOAD_BITS*C_MAX_FIELD_BYTES-1:0] out_value,
  output logic [$clog2(C_MAX_FIELD_BYTES+1)-1:0] out_nbytes,
  output logic                                   out_err,
  output logic                                   out_last,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [C_STAT_WIDTH-1:0]                stat_fields,
  output logic [C_STAT_WIDTH-1:0]                stat_errors
);

  localparam int VAL_W = PAYLOAD_BITS * C_MAX_FIELD_BYTES;
  localparam int NB_W  = $clog2(C_MAX_FIELD_BYTES + 1);
  localparam int PTR_W = (C_LANES > 1) ? $clog2(C_LANES) : 1;
  // acc_cnt saturates at MAX+1, plus up to a full beat in one cycle
  localparam int CNT_W = $clog2(C_MAX_FIELD_BYTES + C_LANES + 2);

  logic [C_LANES-1:0][7:0] lane_byte;
  logic [C_LANES-1:0]      lane_keep, lane_stop;

  logic [PTR_W-1:0] ptr, s;
  logic [VAL_W-1:0] acc, merged;
  logic [CNT_W-1:0] acc_cnt, n_take, cnt_sum, acc_cnt_sat;
  logic             found, remaining, work, emit, err_nxt, last_nxt;
  logic [NB_W-1:0]  nbytes_nxt;

  // Lane 0 is the most significant byte of the beat (first on the wire).
  for (genvar g = 0; g < C_LANES; g++) begin : g_lane
    assign lane_byte[g] = in_tdata[(C_LANES-g)*8-1 -: 8];
    assign lane_keep[g] = in_tkeep[C_LANES-1-g];
    assign lane_stop[g] = is_stop(lane_byte[g]);
  end

  stopbit_priority_enc #(.C_LANES(C_LANES), .PTR_W(PTR_W)) u_penc (
    .keep              (lane_keep),
    .stop              (lane_stop),
    .ptr               (ptr),
    .found             (found),
    .s                 (s),
    .remaining_after_s (remaining)
  );

  // Shift the consumed lanes' payloads under the accumulator; upper bits of
  // an overlong field fall off the top.
  always_comb begin
    merged = acc;
    n_take = '0;
    for (int i = 0; i < C_LANES; i++) begin
      if (i >= int'(ptr) && (!found || i <= int'(s)) && lane_keep[i]) begin
        merged = {merged[VAL_W-PAYLOAD_BITS-1:0], payload_of(lane_byte[i])};
        n_take = n_take + CNT_W'(1);
      end
    end
    cnt_sum     = acc_cnt + n_take;
    acc_cnt_sat = (cnt_sum > CNT_W'(C_MAX_FIELD_BYTES + 1)) ?
                  CNT_W'(C_MAX_FIELD_BYTES + 1) : cnt_sum;
    nbytes_nxt  = (cnt_sum > CNT_W'(C_MAX_FIELD_BYTES)) ?
                  NB_W'(C_MAX_FIELD_BYTES) : NB_W'(cnt_sum);
  end

  assign work      = in_tvalid && (!out_valid || out_ready);
  // A stop ends a field; tlast without a stop flushes an open field as an error.
  assign emit      = found || (in_tlast && cnt_sum != '0);
  assign err_nxt   = found ? (cnt_sum > CNT_W'(C_MAX_FIELD_BYTES)) : 1'b1;
  assign last_nxt  = found ? (!remaining && in_tlast) : 1'b1;
  assign in_tready = work && (!found || !remaining);

  // Lane pointer and cross-beat accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr     <= '0;
      acc     <= '0;
      acc_cnt <= '0;
    end else if (work) begin
      ptr <= (found && remaining) ? s + PTR_W'(1) : '0;
      if (emit) begin
        acc     <= '0;
        acc_cnt <= '0;
      end else begin
        acc     <= merged;
        acc_cnt <= acc_cnt_sat;
      end
    end
  end

  // Output register: reload on a work cycle, drain when accepted, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_value  <= '0;
      out_nbytes <= '0;
      out_err    <= 1'b0;
      out_last   <= 1'b0;
    end else if (work) begin
      out_valid <= emit;
      if (emit) begin
        out_value  <= merged;
        out_nbytes <= nbytes_nxt;
        out_err    <= err_nxt;
        out_last   <= last_nxt;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Statistics count accepted fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_fields <= '0;
      stat_errors <= '0;
    end else if (out_valid && out_ready) begin
      stat_fields <= stat_fields + C_STAT_WIDTH'(1);
      if (out_err) stat_errors <= stat_errors + C_STAT_WIDTH'(1);
    end
  end

endmodule
